// File: rtl/piso_shift_register.sv
// Parallel-in, serial-out unloader with valid/ready handshakes on both sides.
// Ports: i_Clk, i_Rst (async, active low), i_D/i_Load/o_Ready (word in),
// i_Clear (sync abort), o_Serial/o_Serial_Valid/i_Serial_Ready (bit out),
// o_Count (bits left incl. current), o_Done (pulse after last bit).
module piso_shift_register #(
    parameter int unsigned         p_WIDTH         = 32,
    parameter logic [p_WIDTH-1:0]  p_INITIAL_VALUE = '0,
    parameter bit                  p_MSB_FIRST     = 1'b1
) (
    input  logic                           i_Clk,
    input  logic                           i_Rst,
    input  logic [p_WIDTH-1:0]             i_D,
    input  logic                           i_Load,
    output logic                           o_Ready,
    input  logic                           i_Clear,
    output logic                           o_Serial,
    output logic                           o_Serial_Valid,
    input  logic                           i_Serial_Ready,
    output logic [$clog2(p_WIDTH+1)-1:0]   o_Count,
    output logic                           o_Done
);

    localparam int unsigned     CW   = $clog2(p_WIDTH + 1);
    localparam logic [CW-1:0]   FULL = CW'(p_WIDTH);
    localparam logic [CW-1:0]   ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state;
    logic [p_WIDTH-1:0] sreg;
    logic [CW-1:0]      count;
    logic               serial_q;
    logic               valid_q;
    logic               ready_q;
    logic               done_q;

    logic [p_WIDTH-1:0] shifted;
    logic               next_bit;
    logic               load_bit;

    // The outgoing bit is kept in its own flop so o_Serial never depends
    // on anything but registered state; the next bit is precomputed here.
    always_comb begin
        shifted  = '0;
        next_bit = 1'b0;
        load_bit = 1'b0;
        if (p_MSB_FIRST) begin
            shifted  = {sreg[p_WIDTH-2:0], 1'b0};
            next_bit = shifted[p_WIDTH-1];
            load_bit = i_D[p_WIDTH-1];
        end else begin
            shifted  = {1'b0, sreg[p_WIDTH-1:1]};
            next_bit = shifted[0];
            load_bit = i_D[0];
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state    <= S_IDLE;
            sreg     <= p_INITIAL_VALUE;
            count    <= '0;
            serial_q <= 1'b0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else if (i_Clear) begin
            // Abort: shift contents are left as they are.
            state    <= S_IDLE;
            count    <= '0;
            serial_q <= 1'b0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (i_Load) begin
                        state    <= S_SHIFT;
                        sreg     <= i_D;
                        count    <= FULL;
                        serial_q <= load_bit;
                        valid_q  <= 1'b1;
                        ready_q  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (i_Serial_Ready) begin
                        if (count == ONE) begin
                            state    <= S_DONE;
                            count    <= '0;
                            serial_q <= 1'b0;
                            valid_q  <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            sreg     <= shifted;
                            count    <= count - ONE;
                            serial_q <= next_bit;
                        end
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state    <= S_IDLE;
                    count    <= '0;
                    serial_q <= 1'b0;
                    valid_q  <= 1'b0;
                    ready_q  <= 1'b1;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign o_Ready        = ready_q;
    assign o_Serial       = serial_q;
    assign o_Serial_Valid = valid_q;
    assign o_Count        = count;
    assign o_Done         = done_q;

endmodule

// File: tb/tb_piso_shift_register.sv
// Scoreboard bench for piso_shift_register: an MSB-first and an
// LSB-first instance driven by the same stimulus.
module tb_piso_shift_register;

    localparam int W  = 32;
    localparam int CW = $clog2(W + 1);

    typedef struct packed {
        logic          b;
        logic [CW-1:0] c;
    } beat_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [W-1:0]  d     = '0;
    logic          load  = 1'b0;
    logic          clear = 1'b0;
    logic          sready = 1'b0;

    logic          ready_o  [2];
    logic          serial_o [2];
    logic          svalid_o [2];
    logic [CW-1:0] cnt_o    [2];
    logic          done_o   [2];

    beat_t q0[$];
    beat_t q1[$];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int acc        = 0;
    int exp_dones  = 0;
    int dones    [2] = '{0, 0};
    int done_cyc [2] = '{0, 0};
    int wpos     [2] = '{0, 0};
    logic [W-1:0] recon0 = '0;
    logic [W-1:0] recon1 = '0;

    piso_shift_register #(
        .p_WIDTH(W), .p_INITIAL_VALUE({W{1'b1}}), .p_MSB_FIRST(1'b1)
    ) u_msb (
        .i_Clk(clk), .i_Rst(rst_n), .i_D(d), .i_Load(load),
        .o_Ready(ready_o[0]), .i_Clear(clear), .o_Serial(serial_o[0]),
        .o_Serial_Valid(svalid_o[0]), .i_Serial_Ready(sready),
        .o_Count(cnt_o[0]), .o_Done(done_o[0])
    );

    piso_shift_register #(
        .p_WIDTH(W), .p_INITIAL_VALUE({W{1'b1}}), .p_MSB_FIRST(1'b0)
    ) u_lsb (
        .i_Clk(clk), .i_Rst(rst_n), .i_D(d), .i_Load(load),
        .o_Ready(ready_o[1]), .i_Clear(clear), .o_Serial(serial_o[1]),
        .o_Serial_Valid(svalid_o[1]), .i_Serial_Ready(sready),
        .o_Count(cnt_o[1]), .o_Done(done_o[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: got timeout want event", name);
    endtask

    task automatic mon(input int k);
        beat_t e;
        int    sz;
        sz = (k == 0) ? q0.size() : q1.size();
        if (svalid_o[k] && sready) begin
            if (sz == 0) begin
                compared++;
                mismatched++;
                $display("FAIL beat_unexpected_dut%0d: got %b want none",
                         k, serial_o[k]);
            end else begin
                if (k == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("serial_dut%0d", k), 64'(serial_o[k]), 64'(e.b));
                chk($sformatf("count_dut%0d", k), 64'(cnt_o[k]), 64'(e.c));
                if (wpos[k] < W) begin
                    if (k == 0) recon0[W-1-wpos[0]] = serial_o[0];
                    else        recon1[wpos[1]]     = serial_o[1];
                end
                wpos[k]++;
            end
        end
        if (done_o[k]) begin
            chk($sformatf("done_pending_dut%0d", k), 64'(sz), 64'd0);
            dones[k]++;
            done_cyc[k] = cyc;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0);
            mon(1);
        end
    end

    task automatic load_word(input logic [W-1:0] w);
        int n;
        n = 0;
        while (!ready_o[0] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready_o[0]) fail("load_wait");
        d    = w;
        load = 1'b1;
        for (int i = 0; i < W; i++) begin
            q0.push_back('{w[W-1-i], CW'(W - i)});
            q1.push_back('{w[i], CW'(W - i)});
        end
        @(posedge clk); #1;
        load   = 1'b0;
        acc    = cyc;
        wpos   = '{0, 0};
        recon0 = '0;
        recon1 = '0;
        exp_dones++;
    endtask

    task automatic wait_done(input int lat);
        int s;
        int n;
        s = dones[0];
        n = 0;
        while (dones[0] == s && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (dones[0] == s) begin
            fail("done_wait");
        end else begin
            chk("done_latency", 64'(done_cyc[0] - acc), 64'(lat));
            chk("done_align", 64'(done_cyc[1]), 64'(done_cyc[0]));
            @(negedge clk);
            chk("done_one_cycle", 64'(done_o[0]), 64'd0);
            chk("ready_after_done", 64'(ready_o[0]), 64'd1);
        end
    endtask

    task automatic wait_beats(input int nb);
        int n;
        n = 0;
        while (wpos[0] < nb && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (wpos[0] < nb) fail("beat_wait");
    endtask

    task automatic chk_idle(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_ready%0d", tag, k), 64'(ready_o[k]), 64'd1);
            chk($sformatf("%s_serial%0d", tag, k), 64'(serial_o[k]), 64'd0);
            chk($sformatf("%s_valid%0d", tag, k), 64'(svalid_o[k]), 64'd0);
            chk($sformatf("%s_count%0d", tag, k), 64'(cnt_o[k]), 64'd0);
            chk($sformatf("%s_done%0d", tag, k), 64'(done_o[k]), 64'd0);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        sready = 1'b1;

        // MSB-first single high bit
        load_word(32'h8000_0000);
        wait_done(W);
        chk("word1_msb", 64'(recon0), 64'h8000_0000);
        chk("word1_lsb", 64'(recon1), 64'h8000_0000);

        // Two set bits, checked via reassembly on the LSB-first side
        load_word(32'h8004_0000);
        wait_done(W);
        chk("word2_lsb", 64'(recon1), 64'h8004_0000);
        chk("word2_msb", 64'(recon0), 64'h8004_0000);

        // Backpressure on beat 4 for 5 cycles
        load_word(32'h8008_0000);
        wait_beats(3);
        sready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", 64'(svalid_o[0]), 64'd1);
            chk("stall_count", 64'(cnt_o[0]), 64'd29);
            chk("stall_serial_msb", 64'(serial_o[0]), 64'd0);
            chk("stall_serial_lsb", 64'(serial_o[1]), 64'd0);
            @(posedge clk); #1;
        end
        sready = 1'b1;
        wait_done(W + 5);
        chk("word3_msb", 64'(recon0), 64'h8008_0000);
        chk("word3_lsb", 64'(recon1), 64'h8008_0000);

        // Load attempt while busy is ignored
        load_word(32'hC3C3_0001);
        wait_beats(5);
        d    = 32'h1234_5678;
        load = 1'b1;
        @(negedge clk);
        chk("busy_ready", 64'(ready_o[0]), 64'd0);
        @(posedge clk); #1;
        load = 1'b0;
        wait_done(W);
        chk("word4_msb", 64'(recon0), 64'hC3C3_0001);
        chk("word4_lsb", 64'(recon1), 64'hC3C3_0001);

        // Clear at beat 10
        load_word(32'hFFFF_0000);
        wait_beats(9);
        sready = 1'b0;
        clear  = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        q0.delete();
        q1.delete();
        exp_dones--;
        @(negedge clk);
        chk_idle("clear");
        sready = 1'b1;
        load_word(32'hA5A5_A5A5);
        wait_done(W);
        chk("word5_msb", 64'(recon0), 64'hA5A5_A5A5);
        chk("word5_lsb", 64'(recon1), 64'hA5A5_A5A5);

        // Reset asserted mid-period at beat 10
        load_word(32'h0FF0_00F0);
        wait_beats(9);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        q0.delete();
        q1.delete();
        exp_dones--;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        load_word(32'hA5A5_A5A5);
        wait_done(W);
        chk("word6_msb", 64'(recon0), 64'hA5A5_A5A5);
        chk("word6_lsb", 64'(recon1), 64'hA5A5_A5A5);

        repeat (3) @(posedge clk);
        chk("done_total_msb", 64'(dones[0]), 64'(exp_dones));
        chk("done_total_lsb", 64'(dones[1]), 64'(exp_dones));
        chk("queue_empty", 64'(q0.size() + q1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
